// File: rtl/mips16_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS16 control loop: FSM states,
// control-word bit positions, PC source selects and opcodes.
package mips16_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2,  ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,  ST_MEMWR  = 4'd5,  ST_EXEC   = 4'd6,  ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,  ST_JUMP   = 4'd9,  ST_HALT   = 4'd10, ST_ADDI   = 4'd11,
    ST_ADDIWB = 4'd12, ST_LUI    = 4'd13
  } state_e;

  localparam logic [3:0] ST_LAST = 4'd13;

  localparam int CW_PC_SRC_HI = 15;
  localparam int CW_PC_SRC_LO = 14;
  localparam int CW_PC_WRITE  = 13;
  localparam int CW_PC_WCOND  = 12;
  localparam int CW_MEM_RD    = 11;
  localparam int CW_MEM_WR    = 10;
  localparam int CW_IORD      = 9;
  localparam int CW_IR_WRITE  = 8;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_RSVD   = 2'b11
  } pc_src_e;

  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4, OP_ADDI = 4'h5, OP_LW = 4'h6, OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8, OP_LUI = 4'h9, OP_HALT = 4'hA, OP_J   = 4'hB;

  // Encodings beyond the last defined state fall back to FETCH.
  function automatic state_e legal_state(logic [3:0] s);
    return (s > ST_LAST) ? ST_FETCH : state_e'(s);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control-unit / datapath / memory signals seen by the fetch sequencer.
interface fetch_sequencer_if;
  logic [15:0] control;
  logic [3:0]  next_state;
  logic [15:0] alu_result;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [3:0]  prev_state;
  logic [3:0]  opcode;
  logic [15:0] ir;
  logic [15:0] pc;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic        stall;
  logic        halted;
  logic        mem_err;

  modport master (
    input  control, next_state, alu_result, alu_out, alu_zero, mem_rdata, mem_ready,
    output prev_state, opcode, ir, pc, mem_addr, mem_rd, mem_wr, stall, halted, mem_err
  );

  modport slave (
    output control, next_state, alu_result, alu_out, alu_zero, mem_rdata, mem_ready,
    input  prev_state, opcode, ir, pc, mem_addr, mem_rd, mem_wr, stall, halted, mem_err
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait tracking: raises stall while an access is pending and latches a
// sticky error once the access has waited MEM_TIMEOUT cycles and is still pending.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic access,
  input  logic mem_ready,
  output logic stall,
  output logic mem_err
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  assign stall = access & ~mem_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (stall) begin
      if (wait_cnt == CW'(MEM_TIMEOUT)) mem_err <= 1'b1;
      else                              wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns FSM state, PC, IR and the memory handshake, and applies
// the control unit's word/next_state on each rising edge unless stalled.
module fetch_sequencer import mips16_ctrl_pkg::*; #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_TIMEOUT = 15
) (
  input logic              clock,
  input logic              reset,
  fetch_sequencer_if.master bus
);
  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ctl;
  logic        halted, rd_req, wr_req, stall, mem_err, advance, pc_load;
  pc_src_e     pc_src;
  logic        unused_cw;

  assign ctl       = bus.control;
  assign unused_cw = ^ctl[7:0];
  assign pc_src    = pc_src_e'(ctl[CW_PC_SRC_HI:CW_PC_SRC_LO]);

  // Requests are gated by reset too, so a reset mid-access drops them at once.
  assign wr_req  = ctl[CW_MEM_WR] & ~halted & ~mem_err & ~reset;
  assign rd_req  = ctl[CW_MEM_RD] & ~ctl[CW_MEM_WR] & ~halted & ~mem_err & ~reset;
  assign advance = ~stall & ~halted & ~mem_err;
  assign pc_load = ctl[CW_PC_WRITE] | (ctl[CW_PC_WCOND] & bus.alu_zero);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .access    (rd_req | wr_req),
    .mem_ready (bus.mem_ready),
    .stall     (stall),
    .mem_err   (mem_err)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (advance) state_d = legal_state(bus.next_state);
  end

  always_comb begin
    halted = (state_q == ST_HALT);
  end

  always_comb begin
    pc_d = pc_q;
    if (advance && pc_load) begin
      case (pc_src)
        PC_SRC_ALU:    pc_d = bus.alu_result;
        PC_SRC_ALUOUT: pc_d = bus.alu_out;
        PC_SRC_JUMP:   pc_d = {pc_q[15:12], ir_q[11:0]};
        default:       pc_d = pc_q;
      endcase
    end
  end

  // rd_req & mem_ready already implies not stalled, halted or in error.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (ctl[CW_IR_WRITE] & rd_req & bus.mem_ready) ir_q <= bus.mem_rdata;
    end
  end

  assign bus.prev_state = state_q;
  assign bus.opcode     = ir_q[15:12];
  assign bus.ir         = ir_q;
  assign bus.pc         = pc_q;
  assign bus.mem_addr   = ctl[CW_IORD] ? bus.alu_out : pc_q;
  assign bus.mem_rd     = rd_req;
  assign bus.mem_wr     = wr_req;
  assign bus.stall      = stall;
  assign bus.halted     = halted;
  assign bus.mem_err    = mem_err;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then
// random traffic, all cross-checked each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam logic [15:0] RPC = 16'h0010;
  localparam int          TMO = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  fetch_sequencer_if bus();
  fetch_sequencer #(.RESET_PC(RPC), .MEM_TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  m_state;
  logic [15:0] m_pc, m_ir;
  bit          m_err, m_last_stall;
  int          m_run;   // consecutive stalled cycles so far

  function automatic bit e_halted();
    return m_state == 4'd10;
  endfunction
  function automatic bit e_wr();
    return bus.control[10] && !e_halted() && !m_err && !reset;
  endfunction
  function automatic bit e_rd();
    return bus.control[11] && !bus.control[10] && !e_halted() && !m_err && !reset;
  endfunction
  function automatic bit e_stall();
    return (e_rd() || e_wr()) && !bus.mem_ready;
  endfunction

  always @(posedge clock) begin
    logic [15:0] npc, nir;
    logic [3:0]  nst;
    bit          st, frozen, rd;
    if (reset) begin
      m_state = 4'd0; m_pc = RPC; m_ir = 16'h0; m_err = 0; m_run = 0; m_last_stall = 0;
    end else begin
      st = e_stall();
      rd = e_rd();
      frozen = st || e_halted() || m_err;
      npc = m_pc; nir = m_ir; nst = m_state;
      if (!frozen) begin
        nst = (bus.next_state > 4'd13) ? 4'd0 : bus.next_state;
        if (bus.control[13] || (bus.control[12] && bus.alu_zero)) begin
          case (bus.control[15:14])
            2'd0: npc = bus.alu_result;
            2'd1: npc = bus.alu_out;
            2'd2: npc = {m_pc[15:12], m_ir[11:0]};
            default: ;
          endcase
        end
        if (bus.control[8] && rd) nir = bus.mem_rdata;
      end
      if (st) begin
        m_run++;
        if (m_run > TMO) m_err = 1;
      end else begin
        m_run = 0;
      end
      m_state = nst; m_pc = npc; m_ir = nir; m_last_stall = st;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("prev_state", 16'(bus.prev_state), 16'(m_state));
      chk("opcode",     16'(bus.opcode),     16'(m_ir[15:12]));
      chk("ir",         bus.ir,              m_ir);
      chk("pc",         bus.pc,              m_pc);
      chk("mem_addr",   bus.mem_addr,        bus.control[9] ? bus.alu_out : m_pc);
      chk("mem_rd",     16'(bus.mem_rd),     16'(e_rd()));
      chk("mem_wr",     16'(bus.mem_wr),     16'(e_wr()));
      chk("stall",      16'(bus.stall),      16'(e_stall()));
      chk("halted",     16'(bus.halted),     16'(e_halted()));
      chk("mem_err",    16'(bus.mem_err),    16'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock); #1;
  endtask
  task automatic probe();
    @(negedge clock);
  endtask
  task automatic setin(logic [15:0] c, logic [3:0] ns, logic rdy,
                       logic [15:0] ar, logic [15:0] ao, logic [15:0] rdata, logic z);
    bus.control = c; bus.next_state = ns; bus.mem_ready = rdy;
    bus.alu_result = ar; bus.alu_out = ao; bus.mem_rdata = rdata; bus.alu_zero = z;
  endtask

  initial begin
    int drought;
    drought = 0;
    // Fetch word: MEM_RD | IR_WRITE | PC_WRITE, PC source alu_result.
    reset = 1'b1;
    setin(16'h2900, 4'd1, 1'b1, 16'h0011, 16'h0000, 16'hB123, 1'b0);
    step();
    cmp_en = 1'b1;
    probe();
    chk("rst_pc", bus.pc, 16'h0010);
    chk("rst_state", 16'(bus.prev_state), 16'h0);
    chk("rst_ir", bus.ir, 16'h0);
    chk("rst_mem_rd", 16'(bus.mem_rd), 16'h0);
    chk("rst_halted", 16'(bus.halted), 16'h0);
    step();
    reset = 1'b0;
    probe();
    chk("fetch_rd", 16'(bus.mem_rd), 16'h1);
    chk("fetch_addr", bus.mem_addr, 16'h0010);
    step();
    probe();
    chk("fetch_ir", bus.ir, 16'hB123);
    chk("fetch_op", 16'(bus.opcode), 16'hB);
    chk("fetch_pc", bus.pc, 16'h0011);
    chk("fetch_state", 16'(bus.prev_state), 16'h1);

    // Three wait states on the next fetch.
    step();
    setin(16'h2900, 4'd0, 1'b0, 16'h0012, 16'h0000, 16'hC456, 1'b0);
    for (int i = 0; i < 3; i++) begin
      probe();
      chk("wait_stall", 16'(bus.stall), 16'h1);
      chk("wait_pc", bus.pc, 16'h0011);
      chk("wait_ir", bus.ir, 16'hB123);
      step();
    end
    bus.mem_ready = 1'b1;
    step();
    probe();
    chk("wait_done_pc", bus.pc, 16'h0012);
    chk("wait_done_ir", bus.ir, 16'hC456);
    chk("wait_done_state", 16'(bus.prev_state), 16'h0);
    chk("wait_no_err", 16'(bus.mem_err), 16'h0);

    // Timeout: ready held low; error lands on the 16th stalled edge.
    step();
    bus.mem_ready = 1'b0;
    bus.alu_result = 16'h0099;
    for (int i = 0; i < 16; i++) begin
      probe();
      chk("tmo_pending", 16'(bus.mem_err), 16'h0);
      step();
    end
    probe();
    chk("tmo_err", 16'(bus.mem_err), 16'h1);
    chk("tmo_rd_drop", 16'(bus.mem_rd), 16'h0);
    chk("tmo_stall_drop", 16'(bus.stall), 16'h0);
    step();
    bus.next_state = 4'd5; bus.mem_ready = 1'b1;
    step(); step();
    probe();
    chk("tmo_frozen_state", 16'(bus.prev_state), 16'h0);
    chk("tmo_frozen_pc", bus.pc, 16'h0012);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    // BEQ: PC_WCOND, source alu_out.
    setin(16'h5000, 4'd0, 1'b1, 16'h0000, 16'h0040, 16'h0000, 1'b0);
    probe();
    chk("rst2_err", 16'(bus.mem_err), 16'h0);
    step();
    probe();
    chk("beq_not_taken", bus.pc, 16'h0010);
    step();
    bus.alu_zero = 1'b1;
    step();
    probe();
    chk("beq_taken", bus.pc, 16'h0040);

    // Jump: pc=5000, ir=B2AB -> 52AB.
    step();
    setin(16'h2000, 4'd0, 1'b1, 16'h5000, 16'h0040, 16'h0000, 1'b0);
    step();
    bus.control = 16'h0900; bus.mem_rdata = 16'hB2AB;
    probe();
    chk("jmp_pc_setup", bus.pc, 16'h5000);
    step();
    bus.control = 16'hA000;
    probe();
    chk("jmp_ir_setup", bus.ir, 16'hB2AB);
    step();
    probe();
    chk("jmp_target", bus.pc, 16'h52AB);

    // Write wins over read; IORD selects alu_out as the address.
    step();
    bus.control = 16'h0E00;
    probe();
    chk("both_wr", 16'(bus.mem_wr), 16'h1);
    chk("both_rd", 16'(bus.mem_rd), 16'h0);
    chk("iord_addr", bus.mem_addr, 16'h0040);

    // Halt, then 20 cycles of hostile control with everything frozen.
    step();
    setin(16'h2900, 4'd10, 1'b1, 16'h0077, 16'h0000, 16'hA000, 1'b0);
    step();
    setin(16'h2900, 4'd0, 1'b1, 16'h1234, 16'h4321, 16'h5555, 1'b1);
    for (int i = 0; i < 20; i++) begin
      probe();
      chk("halt_flag", 16'(bus.halted), 16'h1);
      chk("halt_pc", bus.pc, 16'h0077);
      chk("halt_ir", bus.ir, 16'hA000);
      step();
      bus.control = 16'($urandom()); bus.mem_rdata = 16'($urandom());
      bus.alu_result = 16'($urandom()); bus.next_state = 4'($urandom());
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    setin(16'h0000, 4'd3, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    probe();
    chk("unhalt_flag", 16'(bus.halted), 16'h0);
    chk("unhalt_pc", bus.pc, 16'h0010);
    step();
    bus.next_state = 4'd15;
    probe();
    chk("ns3", 16'(bus.prev_state), 16'h3);
    step();
    probe();
    chk("ns15_fetch", 16'(bus.prev_state), 16'h0);

    // Random traffic; control repeats while the previous cycle stalled.
    for (int n = 0; n < 3000; n++) begin
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 49) == 0) reset = 1'b1;
      if (!m_last_stall || reset) begin
        bus.control    = 16'($urandom());
        bus.next_state = 4'($urandom_range(0, 15));
        if (bus.next_state == 4'd10 && $urandom_range(0, 7) != 0) bus.next_state = 4'd1;
        bus.alu_result = 16'($urandom());
        bus.alu_out    = 16'($urandom());
        bus.mem_rdata  = 16'($urandom());
        bus.alu_zero   = 1'($urandom());
      end
      if (drought > 0) begin
        bus.mem_ready = 1'b0;
        drought--;
      end else if ($urandom_range(0, 149) == 0) begin
        bus.mem_ready = 1'b0;
        drought = 20;
      end else begin
        bus.mem_ready = ($urandom_range(0, 3) != 0);
      end
    end
    probe();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
